// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one sequential signed multiplier between NREQ requesters.
// It grants one requester at a time, launches the multiplier, and returns the product with a done strobe.
module mult_arbiter #(
    parameter int DW   = 8,
    parameter int NREQ = 4,
    parameter int TMO  = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*DW-1:0]   i_multd,
    input  logic [NREQ*DW-1:0]   i_multr,
    output logic [NREQ-1:0]      o_gnt,
    output logic [NREQ-1:0]      o_done,
    output logic [2*DW-1:0]      o_result,
    output logic                 o_err,
    output logic                 o_busy,
    output logic                 o_mult_start,
    output logic [DW-1:0]        o_mult_multd,
    output logic [DW-1:0]        o_mult_multr,
    input  logic                 i_mult_ready,
    input  logic [2*DW-1:0]      i_mult_result
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TMO + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LAUNCH    = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_RESPOND   = 3'd4;

    logic [2:0]       state_q,  state_d;
    logic [PW-1:0]    ptr_q,    ptr_d;
    logic [PW-1:0]    idx_q,    idx_d;
    logic [NREQ-1:0]  gnt_q,    gnt_d;
    logic [DW-1:0]    multd_q,  multd_d;
    logic [DW-1:0]    multr_q,  multr_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [2*DW-1:0]  result_q, result_d;
    logic             err_q,    err_d;

    logic             req_any;
    logic [PW-1:0]    win_idx;
    logic [NREQ-1:0]  win_onehot;
    logic             timed_out;
    logic [PW-1:0]    ptr_next;

    // Rotating scan: first set request at ptr, ptr+1, ... with wrap-around.
    always_comb begin
        int k;
        k          = 0;
        req_any    = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(ptr_q) + i) % NREQ;
            if (!req_any && i_req[k]) begin
                req_any = 1'b1;
                win_idx = PW'(k);
            end
        end
        if (req_any) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

    assign timed_out = (cnt_q == CW'(TMO));
    assign ptr_next  = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        gnt_d    = gnt_q;
        multd_d  = multd_q;
        multr_d  = multr_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    idx_d    = win_idx;
                    gnt_d    = win_onehot;
                    multd_d  = i_multd[int'(win_idx)*DW +: DW];
                    multr_d  = i_multr[int'(win_idx)*DW +: DW];
                    result_d = '0;
                    err_d    = 1'b0;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (timed_out) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESPOND;
                end else if (!i_mult_ready) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (timed_out) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESPOND;
                end else if (i_mult_ready) begin
                    result_d = i_mult_result;
                    state_d  = S_RESPOND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESPOND: begin
                gnt_d   = '0;
                ptr_d   = ptr_next;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            gnt_q    <= '0;
            multd_q  <= '0;
            multr_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            gnt_q    <= gnt_d;
            multd_q  <= multd_d;
            multr_q  <= multr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Done, result and error are only meaningful in the single RESPOND cycle.
    assign o_gnt        = gnt_q;
    assign o_done       = (state_q == S_RESPOND) ? gnt_q : '0;
    assign o_result     = (state_q == S_RESPOND) ? result_q : '0;
    assign o_err        = (state_q == S_RESPOND) && err_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_mult_start = (state_q == S_LAUNCH);
    assign o_mult_multd = multd_q;
    assign o_mult_multr = multr_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural sequential multiplier and an expected-result queue.
module tb_mult_arbiter;

    localparam int DW   = 8;
    localparam int NREQ = 4;
    localparam int TMO  = 64;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic [NREQ-1:0]      i_req = '0;
    logic [NREQ*DW-1:0]   i_multd = '0;
    logic [NREQ*DW-1:0]   i_multr = '0;
    logic [NREQ-1:0]      o_gnt;
    logic [NREQ-1:0]      o_done;
    logic [2*DW-1:0]      o_result;
    logic                 o_err;
    logic                 o_busy;
    logic                 o_mult_start;
    logic [DW-1:0]        o_mult_multd;
    logic [DW-1:0]        o_mult_multr;
    logic                 i_mult_ready;
    logic [2*DW-1:0]      i_mult_result;

    typedef struct {
        int              idx;
        logic [2*DW-1:0] result;
        logic            err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    logic stuck_low = 1'b0;
    int   model_cnt = 0;
    logic signed [DW-1:0] ma = '0;
    logic signed [DW-1:0] mb = '0;

    int   cyc = 0;
    int   start_count = 0;
    int   last_start_cyc = 0;
    logic gnt_bad = 1'b0;

    mult_arbiter #(.DW(DW), .NREQ(NREQ), .TMO(TMO)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .i_multd      (i_multd),
        .i_multr      (i_multr),
        .o_gnt        (o_gnt),
        .o_done       (o_done),
        .o_result     (o_result),
        .o_err        (o_err),
        .o_busy       (o_busy),
        .o_mult_start (o_mult_start),
        .o_mult_multd (o_mult_multd),
        .o_mult_multr (o_mult_multr),
        .i_mult_ready (i_mult_ready),
        .i_mult_result(i_mult_result)
    );

    always #5 i_clk = ~i_clk;

    // Multiplier model: drops ready for three cycles after start, unless stuck_low holds it down.
    always @(posedge i_clk) begin
        if (i_rst) begin
            i_mult_ready  <= 1'b1;
            i_mult_result <= '0;
            model_cnt     <= 0;
        end else if (o_mult_start) begin
            i_mult_ready <= 1'b0;
            ma           <= o_mult_multd;
            mb           <= o_mult_multr;
            model_cnt    <= stuck_low ? 0 : 3;
        end else if (model_cnt > 1) begin
            model_cnt <= model_cnt - 1;
        end else if (model_cnt == 1) begin
            model_cnt     <= 0;
            i_mult_ready  <= 1'b1;
            i_mult_result <= ma * mb;
        end else if (!stuck_low) begin
            i_mult_ready <= 1'b1;
        end
    end

    always @(negedge i_clk) begin
        cyc <= cyc + 1;
        if (o_mult_start) begin
            start_count    <= start_count + 1;
            last_start_cyc <= cyc;
        end
        if (!$onehot0(o_gnt)) gnt_bad <= 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic req);
        i_multd[k*DW +: DW] = a;
        i_multr[k*DW +: DW] = b;
        i_req[k]            = req;
    endtask

    task automatic expectTxn(input int k, input logic [2*DW-1:0] res, input logic err);
        exp_t e;
        e.idx    = k;
        e.result = res;
        e.err    = err;
        sb.push_back(e);
    endtask

    task automatic waitDone(input int budget);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (o_done === '0 && n < budget);
        if (o_done === '0) begin
            checks++;
            failures++;
            $error("[TB] FAIL wait_done observed=no_done expected=done_within_%0d", budget);
        end else if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL unexpected_done observed=%0h expected=none", o_done);
        end else begin
            e = sb.pop_front();
            checkOutput("done_onehot", 32'(o_done), 32'(1) << e.idx);
            checkOutput("result", 32'(o_result), 32'(e.result));
            checkOutput("err", 32'(o_err), 32'(e.err));
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_gnt"},    32'(o_gnt), 0);
        checkOutput({tag, "_done"},   32'(o_done), 0);
        checkOutput({tag, "_result"}, 32'(o_result), 0);
        checkOutput({tag, "_err"},    32'(o_err), 0);
        checkOutput({tag, "_busy"},   32'(o_busy), 0);
        checkOutput({tag, "_start"},  32'(o_mult_start), 0);
        checkOutput({tag, "_multd"},  32'(o_mult_multd), 0);
        checkOutput({tag, "_multr"},  32'(o_mult_multr), 0);
    endtask

    initial begin
        int s0;
        logic [DW-1:0]   t3a [NREQ];
        logic [DW-1:0]   t3b [NREQ];
        logic [2*DW-1:0] t3p [NREQ];
        logic [DW-1:0]   t4a [3];
        logic [DW-1:0]   t4b [3];
        logic [2*DW-1:0] t4p [3];
        t3a = '{8'd2, 8'd3, 8'd4, 8'd5};
        t3b = '{8'hFF, 8'hFD, 8'hFB, 8'hF9};
        t3p = '{16'hFFFE, 16'hFFF7, 16'hFFEC, 16'hFFDD};
        t4a = '{8'h80, 8'h80, 8'h00};
        t4b = '{8'h80, 8'h7F, 8'hFF};
        t4p = '{16'h4000, 16'hC080, 16'h0000};

        // Reset state
        repeat (3) @(negedge i_clk);
        checkIdleOutputs("reset");
        i_rst = 1'b0;

        // Single requester, -7 x -7
        applyStimulus(0, 8'hF9, 8'hF9, 1'b1);
        expectTxn(0, 16'h0031, 1'b0);
        s0 = start_count;
        @(negedge i_clk);
        checkOutput("t1_gnt", 32'(o_gnt), 32'h1);
        checkOutput("t1_start", 32'(o_mult_start), 1);
        checkOutput("t1_multd", 32'(o_mult_multd), 32'hF9);
        checkOutput("t1_multr", 32'(o_mult_multr), 32'hF9);
        applyStimulus(0, 8'h00, 8'h00, 1'b0);
        waitDone(20);
        checkOutput("t1_latency", 32'(cyc - last_start_cyc), 5);
        @(negedge i_clk);
        checkOutput("t1_idle_busy", 32'(o_busy), 0);
        checkOutput("t1_idle_gnt", 32'(o_gnt), 0);
        checkOutput("t1_idle_result", 32'(o_result), 0);
        checkOutput("t1_one_start", 32'(start_count - s0), 1);

        // Two simultaneous requests after reset
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        applyStimulus(1, 8'd7, 8'd7, 1'b1);
        applyStimulus(3, 8'd3, 8'hFB, 1'b1);
        expectTxn(1, 16'h0031, 1'b0);
        expectTxn(3, 16'hFFF1, 1'b0);
        waitDone(20);
        applyStimulus(1, 8'd7, 8'd7, 1'b0);
        waitDone(20);
        applyStimulus(3, 8'd3, 8'hFB, 1'b0);
        @(negedge i_clk);

        // All requesters held high: strict rotation with one idle cycle between transactions
        for (int k = 0; k < NREQ; k++) applyStimulus(k, t3a[k], t3b[k], 1'b1);
        for (int t = 0; t < 6; t++) expectTxn(t % NREQ, t3p[t % NREQ], 1'b0);
        s0 = start_count;
        for (int t = 0; t < 6; t++) begin
            waitDone(30);
            if (t == 5) begin
                i_req = '0;
            end else begin
                @(negedge i_clk);
                checkOutput("t3_idle_gap", 32'(o_busy), 0);
                @(negedge i_clk);
                checkOutput("t3_relaunch", 32'(o_busy), 1);
                checkOutput("t3_next_gnt", 32'(o_gnt), 32'(1) << ((t + 1) % NREQ));
            end
        end
        @(negedge i_clk);
        checkOutput("t3_starts", 32'(start_count - s0), 6);

        // Signed extremes
        for (int t = 0; t < 3; t++) begin
            applyStimulus(2, t4a[t], t4b[t], 1'b1);
            expectTxn(2, t4p[t], 1'b0);
            waitDone(20);
            applyStimulus(2, t4a[t], t4b[t], 1'b0);
            @(negedge i_clk);
        end

        // Multiplier never completes: timeout with error, then normal service
        stuck_low = 1'b1;
        applyStimulus(0, 8'd5, 8'd6, 1'b1);
        expectTxn(0, 16'h0000, 1'b1);
        waitDone(TMO + 40);
        checkOutput("t5_tmo_in_range",
                    32'((cyc - last_start_cyc >= TMO) && (cyc - last_start_cyc <= TMO + 4)), 1);
        applyStimulus(0, 8'd5, 8'd6, 1'b0);
        stuck_low = 1'b0;
        repeat (2) @(negedge i_clk);
        applyStimulus(1, 8'd4, 8'd4, 1'b1);
        expectTxn(1, 16'h0010, 1'b0);
        waitDone(20);
        applyStimulus(1, 8'd4, 8'd4, 1'b0);
        @(negedge i_clk);

        // Reset during WAIT_DONE abandons the transaction and clears the pointer
        applyStimulus(3, 8'd10, 8'hFD, 1'b1);
        @(negedge i_clk);
        checkOutput("t6_gnt", 32'(o_gnt), 32'h8);
        @(negedge i_clk);
        @(negedge i_clk);
        checkOutput("t6_busy_before_rst", 32'(o_busy), 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        checkIdleOutputs("t6_rst");
        i_rst = 1'b0;
        applyStimulus(1, 8'd6, 8'd6, 1'b1);
        expectTxn(1, 16'h0024, 1'b0);
        expectTxn(3, 16'hFFE2, 1'b0);
        waitDone(20);
        applyStimulus(1, 8'd6, 8'd6, 1'b0);
        waitDone(20);
        applyStimulus(3, 8'd10, 8'hFD, 1'b0);
        @(negedge i_clk);

        checkOutput("sb_drained", 32'(sb.size()), 0);
        checkOutput("gnt_onehot", 32'(gnt_bad), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=stalled expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Round-robin controller that shares one sequential signed multiplier between NREQ requesters. It arbitrates requests and latches the winner's operands. It pulses the multiplier start, waits for the multiplier's ready handshake, and returns the product to the winner with a one-cycle done strobe. It sits between the requester logic and the multiplier core (operands in, o_ready/product out) and owns the multiplier's start line exclusively.

Parameters:
DW, 8, signed operand width in bits; product width is 2*DW.
NREQ, 4, number of requesters (2..8).
TMO, 64, maximum cycles spent waiting on the multiplier before declaring an error.

Ports:
i_clk  in  1  system clock, all logic on rising edge.
i_rst  in  1  reset, synchronous, active-high.
i_req  in  NREQ  per-requester request level.
i_multd  in  NREQ*DW  flat multiplicands; requester k at bits [k*DW +: DW], two's complement.
i_multr  in  NREQ*DW  flat multipliers, same packing.
o_gnt  out  NREQ  one-hot grant, held for the whole transaction.
o_done  out  NREQ  one-hot, one-cycle completion strobe.
o_result  out  2*DW  signed product; valid only in the o_done cycle, otherwise 0.
o_err  out  1  high with o_done when the transaction timed out.
o_busy  out  1  high in any state other than IDLE.
o_mult_start  out  1  one-cycle start pulse to the multiplier.
o_mult_multd  out  DW  latched multiplicand to the multiplier.
o_mult_multr  out  DW  latched multiplier to the multiplier.
i_mult_ready  in  1  multiplier idle/result-valid level.
i_mult_result  in  2*DW  multiplier product, valid while i_mult_ready is high after a run.

Behaviour:
- Reset (i_rst=1 at an edge):
  - FSM goes to IDLE; priority pointer goes to 0; timeout counter goes to 0.
  - All outputs read 0 from the next cycle. Operand registers clear to 0.
  - Reset mid-transaction abandons it with no o_done. The multiplier shares i_rst and is reset the same way.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESPOND.
- IDLE:
  - When any i_req bit is high, select the first set bit at index ptr, ptr+1, ... NREQ-1, 0, ... (wrapping).
  - Latch that requester's operands into o_mult_multd/o_mult_multr, set o_gnt one-hot, and go to LAUNCH.
  - No request: stay in IDLE.
- LAUNCH: o_mult_start=1 for exactly this cycle; clear the counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - i_mult_ready=0 → WAIT_DONE, since the multiplier has accepted the start.
  - Otherwise increment the counter.
- WAIT_DONE:
  - i_mult_ready=1 → capture i_mult_result and go to RESPOND.
  - Otherwise increment the counter.
- Timeout: the counter reaching TMO in WAIT_BUSY or WAIT_DONE forces RESPOND with o_err=1 and result 0.
- RESPOND (one cycle):
  - o_done[g]=1, o_result=captured product, o_err as determined.
  - ptr ← (g+1) mod NREQ. o_gnt clears and the FSM returns to IDLE on the next edge.
- Latency (fault-free): request seen in IDLE at cycle N → start at N+1. Done arrives 1 cycle after the cycle in which ready is seen high in WAIT_DONE.
- Requester rules:
  - Operands are latched at grant, so requesters may change them after o_gnt rises.
  - A request still high after its o_done is a new request. It is arbitrated normally, and the rotated ptr gives the other requesters precedence.
  - Dropping i_req while granted has no effect; the transaction completes and o_done still pulses.
- Only one transaction is ever in flight. Requests arriving while busy wait; they are never dropped or queued beyond their level.
- Product is passed through unmodified, full 2*DW signed with no truncation. No arithmetic is done in this block.
- Multiplier ready stuck high after start (start missed): times out via WAIT_BUSY. Ready stuck low: times out via WAIT_DONE.

Test Plan:
1. DW=8, NREQ=4, req0 alone with -7 × -7 → o_gnt=0001, one start pulse, o_done=0001 with o_result=0x0031 (49), o_err=0; return to IDLE the next cycle.
2. After reset (ptr=0), req1 (7×7) and req3 (3×-5) raised in the same cycle → req1 served first with 49, then req3 with 0xFFF1 (-15); never overlapping.
3. All four reqs held high continuously → grant order 0,1,2,3,0,1; exactly one start per grant; o_busy drops for exactly one IDLE cycle between transactions.
4. Signed extremes: -128×-128 → 0x4000; -128×127 → 0xC080; 0×-1 → 0x0000; results match bit-exactly.
5. Multiplier model holding i_mult_ready=0 forever after start → o_done and o_err high together after TMO=64 waiting cycles with o_result=0. Next request then served normally.
6. i_rst asserted for one cycle during WAIT_DONE → next cycle all outputs 0, no o_done for the aborted request, ptr=0. A held request is re-granted afterwards.
